// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: widths, ALU opcode codes,
// RV64I major opcodes and the issued-entry record.
package alu_issue_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // ALU opcode codes, identical to the ones the ALU decodes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // RV64I major opcodes and the alternate funct7/funct6 encodings
    localparam logic [6:0] RV_OP     = 7'b0110011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [5:0] F6_SRA    = 6'b010000;

    // One decoded entry as presented to the ALU
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      opcode;
        logic [4:0]      rd;
        logic            illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of one RV64I OP / OP-IMM instruction into an ALU entry.
// Anything that is not a legal OP/OP-IMM encoding becomes an ADD of zeros
// to x0 with the illegal flag raised, so it still flows down the pipe.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output issue_entry_t    entry_o
);

    logic [6:0]      major;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [5:0]      funct6;
    logic [XLEN-1:0] shamt_zx;
    logic [XLEN-1:0] imm_sx;

    assign major    = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7   = instr_i[31:25];
    assign funct6   = instr_i[31:26];
    assign shamt_zx = {{(XLEN-6){1'b0}}, instr_i[25:20]};
    assign imm_sx   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

    logic            legal;
    logic [3:0]      op_v;
    logic [XLEN-1:0] b_v;

    // Field decode and legality; instr[30] selects SUB/SRA only for register ops
    always_comb begin
        legal = 1'b0;
        op_v  = ALU_ADD;
        b_v   = '0;
        case (major)
            RV_OP: begin
                b_v  = rs2_data_i;
                op_v = {instr_i[30], funct3};
                legal = (funct7 == 7'b0000000) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            RV_OP_IMM: begin
                case (funct3)
                    3'b001: begin
                        b_v   = shamt_zx;
                        op_v  = ALU_SLL;
                        legal = (funct6 == 6'b000000);
                    end
                    3'b101: begin
                        b_v = shamt_zx;
                        if (funct6 == 6'b000000) begin
                            op_v  = ALU_SRL;
                            legal = 1'b1;
                        end else if (funct6 == F6_SRA) begin
                            op_v  = ALU_SRA;
                            legal = 1'b1;
                        end
                    end
                    default: begin
                        // instr[30] is immediate data here, so ADDI never becomes SUB
                        b_v   = imm_sx;
                        op_v  = {1'b0, funct3};
                        legal = 1'b1;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings are scrubbed to a harmless ADD of zeros to x0
    always_comb begin
        if (legal) begin
            entry_o.a       = rs1_data_i;
            entry_o.b       = b_v;
            entry_o.opcode  = op_v;
            entry_o.rd      = instr_i[11:7];
            entry_o.illegal = 1'b0;
        end else begin
            entry_o.a       = '0;
            entry_o.b       = '0;
            entry_o.opcode  = ALU_ADD;
            entry_o.rd      = 5'd0;
            entry_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 64-bit ALU: decode plus a main output
// register and one skid register, so in_ready is a flop and never depends
// combinationally on out_ready.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   ST_EMPTY | no entry held, out_valid=0
//   ST_ONE   | main register valid, skid free
//   ST_FULL  | main and skid valid, in_ready=0
module alu_issue_stage
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_opcode,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]   state_q, state_d;
    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    issue_entry_t dec_entry;
    logic         accept;
    logic         drain;

    alu_issue_decode u_decode (
        .instr_i    (instr),
        .rs1_data_i (rs1_data),
        .rs2_data_i (rs2_data),
        .entry_o    (dec_entry)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    assign alu_a      = main_q.a;
    assign alu_b      = main_q.b;
    assign alu_opcode = main_q.opcode;
    assign rd         = main_q.rd;
    assign illegal    = main_q.illegal;

    // Occupancy transitions; skid only fills when main is held, so order stays FIFO
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = dec_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = dec_entry;
                    end else if (accept) begin
                        skid_d  = dec_entry;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready is computed from the next state so it can be presented from a flop
    always_comb begin
        in_ready_d = (state_d != ST_FULL);
    end

    // State and data registers; reset also clears the held data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [4:0]  rd;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .rd         (rd),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   zero_exp;
    int   checks   = 0;
    int   failures = 0;

    // Reference decode written from the instruction-set rules
    function automatic exp_t ref_decode(logic [31:0] ins, logic [63:0] r1, logic [63:0] r2);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  hi6;
        logic [11:0] imm;
        bit          ok;
        f3  = ins[14:12];
        f7  = ins[31:25];
        hi6 = ins[31:26];
        imm = ins[31:20];
        ok  = 0;
        e   = '0;
        if (ins[6:0] == 7'h33) begin
            if (f7 == 7'h00) begin
                ok = 1; e.op = {1'b0, f3};
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ok = 1; e.op = {1'b1, f3};
            end
            e.b = r2;
        end else if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1) begin
                ok = (hi6 == 6'd0); e.op = 4'd1; e.b = 64'(ins[25:20]);
            end else if (f3 == 3'd5) begin
                e.b = 64'(ins[25:20]);
                if (hi6 == 6'd0) begin ok = 1; e.op = 4'd5; end
                else if (hi6 == 6'd16) begin ok = 1; e.op = 4'd13; end
            end else begin
                ok = 1; e.op = {1'b0, f3};
                e.b = 64'($signed(imm));
            end
        end
        if (ok) begin
            e.a = r1; e.rd = ins[11:7]; e.ill = 0;
        end else begin
            e = '0; e.ill = 1;
        end
        return e;
    endfunction

    // Advance the model by the current inputs, then one clock; ends on a negedge
    task automatic step();
        bit acc;
        bit drn;
        if (rst) begin
            q.delete();
            zero_exp = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(instr, rs1_data, rs2_data));
                zero_exp = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_type(logic [6:0] f7, logic [2:0] f3, logic [4:0] d);
        return {f7, 5'd2, 5'd1, f3, d, 7'h33};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end else if (sel < 8) begin
            w[6:0] = 7'h13;
            case ($urandom_range(0, 2))
                0: w[31:26] = 6'd0;
                1: w[31:26] = 6'd16;
                default: ;
            endcase
        end else if (sel == 8) begin
            w[6:0] = 7'h6F;
        end
        return w;
    endfunction

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 1; out_ready = 0;
        instr = 32'h002081B3; rs1_data = 64'h1234; rs2_data = 64'h5678;
        step();
        step();
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if ({alu_a, alu_b, alu_opcode, rd, illegal} !== '0)
            begin failures++; $display("FAIL reset_data got a=%h b=%h op=%b rd=%0d ill=%b exp=all zero", alu_a, alu_b, alu_opcode, rd, illegal); end
    endtask

    task automatic test_add();
        out_ready = 1; in_valid = 1;
        instr = 32'h002081B3; rs1_data = 64'h7FFF_FFFF_FFFF_FFFF; rs2_data = 64'd1;
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, alu_opcode, alu_a, alu_b, rd, illegal} !== {1'b1, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 1'b0})
            begin failures++; $display("FAIL add got v=%b op=%b a=%h b=%h rd=%0d ill=%b exp v=1 op=0000 a=7fffffffffffffff b=1 rd=3 ill=0", out_valid, alu_opcode, alu_a, alu_b, rd, illegal); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back_imm();
        out_ready = 1; in_valid = 1;
        instr = 32'hFFF00293; rs1_data = 64'd0; rs2_data = 64'hDEAD;
        step();
        instr = 32'h43F0D313; rs1_data = 64'h8000_0000_0000_0000;
        checks++;
        if ({alu_opcode, alu_b, rd, illegal} !== {4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b0})
            begin failures++; $display("FAIL addi got op=%b b=%h rd=%0d ill=%b exp op=0000 b=ffffffffffffffff rd=5 ill=0", alu_opcode, alu_b, rd, illegal); end
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, alu_opcode, alu_a, alu_b, rd} !== {1'b1, 4'b1101, 64'h8000_0000_0000_0000, 64'h3F, 5'd6})
            begin failures++; $display("FAIL srai got v=%b op=%b a=%h b=%h rd=%0d exp v=1 op=1101 a=8000000000000000 b=3f rd=6", out_valid, alu_opcode, alu_a, alu_b, rd); end
        step();
    endtask

    task automatic test_stall();
        out_ready = 0; in_valid = 1; rs1_data = 64'h11; rs2_data = 64'h22;
        instr = r_type(7'h00, 3'd0, 5'd7);
        step();
        checks++;
        if ({out_valid, in_ready, rd} !== {1'b1, 1'b1, 5'd7})
            begin failures++; $display("FAIL stall_one got v=%b rdy=%b rd=%0d exp v=1 rdy=1 rd=7", out_valid, in_ready, rd); end
        instr = r_type(7'h20, 3'd0, 5'd8);
        step();
        checks++;
        if ({out_valid, in_ready, rd} !== {1'b1, 1'b0, 5'd7})
            begin failures++; $display("FAIL stall_full got v=%b rdy=%b rd=%0d exp v=1 rdy=0 rd=7", out_valid, in_ready, rd); end
        instr = r_type(7'h00, 3'd4, 5'd9);
        step();
        checks++;
        if ({out_valid, in_ready, rd, alu_opcode} !== {1'b1, 1'b0, 5'd7, 4'b0000})
            begin failures++; $display("FAIL stall_hold got v=%b rdy=%b rd=%0d op=%b exp v=1 rdy=0 rd=7 op=0000", out_valid, in_ready, rd, alu_opcode); end
        out_ready = 1;
        step();
        checks++;
        if ({out_valid, in_ready, rd, alu_opcode} !== {1'b1, 1'b1, 5'd8, 4'b1000})
            begin failures++; $display("FAIL stall_second got v=%b rdy=%b rd=%0d op=%b exp v=1 rdy=1 rd=8 op=1000", out_valid, in_ready, rd, alu_opcode); end
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, rd, alu_opcode} !== {1'b1, 5'd9, 4'b0100})
            begin failures++; $display("FAIL stall_third got v=%b rd=%0d op=%b exp v=1 rd=9 op=0100", out_valid, rd, alu_opcode); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1; in_valid = 1;
        instr = 32'h0000006F; rs1_data = 64'hAAAA; rs2_data = 64'hBBBB;
        step();
        checks++;
        if ({illegal, alu_opcode, alu_a, alu_b, rd} !== {1'b1, 4'b0000, 64'd0, 64'd0, 5'd0})
            begin failures++; $display("FAIL illegal_jal got ill=%b op=%b a=%h b=%h rd=%0d exp ill=1 op=0000 a=0 b=0 rd=0", illegal, alu_opcode, alu_a, alu_b, rd); end
        instr = r_type(7'h20, 3'd6, 5'd4);
        step();
        in_valid = 0;
        checks++;
        if ({out_valid, illegal, alu_a, rd} !== {1'b1, 1'b1, 64'd0, 5'd0})
            begin failures++; $display("FAIL illegal_funct7 got v=%b ill=%b a=%h rd=%0d exp v=1 ill=1 a=0 rd=0", out_valid, illegal, alu_a, rd); end
        step();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; rs1_data = 64'h33; rs2_data = 64'h44;
        instr = r_type(7'h00, 3'd0, 5'd10);
        step();
        instr = r_type(7'h00, 3'd0, 5'd11);
        step();
        flush = 1; instr = r_type(7'h00, 3'd0, 5'd12);
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            begin failures++; $display("FAIL flush_state got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0)
                begin failures++; $display("FAIL flush_leak cycle=%0d got v=%b rd=%0d exp v=0", i, out_valid, rd); end
        end
    endtask

    task automatic test_random();
        exp_t got;
        for (int n = 0; n < 600; n++) begin
            got = {alu_a, alu_b, alu_opcode, rd, illegal};
            checks++;
            if (out_valid !== (q.size() > 0))
                begin failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, q.size() > 0); end
            checks++;
            if (in_ready !== (q.size() < 2))
                begin failures++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++;
                if (got !== q[0])
                    begin failures++; $display("FAIL rand_entry n=%0d got=%h exp=%h", n, got, q[0]); end
            end else if (zero_exp) begin
                checks++;
                if (got !== '0)
                    begin failures++; $display("FAIL rand_reset_data n=%0d got=%h exp=0", n, got); end
            end
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = rand_instr();
            rs1_data  = {$urandom, $urandom};
            rs2_data  = {$urandom, $urandom};
            step();
        end
        rst = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        zero_exp = 1;
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back_imm();
        test_stall();
        test_illegal();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
